key_seg_display: RTL and testbench

- Downstream consumer of the keypad/result-streaming stage; accepts its Key_Flag/Key_Value code stream.
- Assembles received decimal digits into an N-digit entry buffer and tracks the last separator/operator code.
- Drives a time-multiplexed 7-segment display.
- Generates the dly_done pacing pulse that the upstream stage uses to step through its digit stream.

---
 rtl/key_seg_display.sv | 186 ++++++++++++++++++
 tb/tb_key_seg_display.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_seg_display.sv
// Keypad code consumer: assembles decimal digits into an entry buffer, tracks the last
// separator code, scans a multiplexed 7-segment display and paces the upstream digit stream.
module key_seg_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int PACE_DIV = 25000000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Key_Flag,
  input  logic [3:0]        Key_Value,
  input  logic              pace_en,
  output logic              dly_done,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg,
  output logic              buf_full,
  output logic [1:0]        op_code
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(DIGITS + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(PACE_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic                       flag_d_r;
  logic [DIGITS-1:0][3:0]     buf_r, buf_nxt_s;
  logic [CNT_W-1:0]           cnt_r, cnt_nxt_s;
  logic [1:0]                 op_r, op_nxt_s;
  logic                       full_r;
  logic                       event_s;

  logic [SCAN_W-1:0]          scan_cnt_r;
  logic [IDX_W-1:0]           idx_r;
  logic [DIGITS-1:0]          sel_r, sel_nxt_s;
  logic [7:0]                 seg_r, seg_nxt_s;

  logic [PACE_W-1:0]          pace_cnt_r, pace_nxt_s;
  logic                       dly_done_r;

  assign event_s = Key_Flag & ~flag_d_r;

  // Next buffer/count/op_code for the code sampled on a rising Key_Flag.
  always_comb begin
    buf_nxt_s = buf_r;
    cnt_nxt_s = cnt_r;
    op_nxt_s  = op_r;
    if (event_s) begin
      if (Key_Value <= 4'd9) begin
        buf_nxt_s = {buf_r[DIGITS-2:0], Key_Value};
        if (cnt_r != CNT_FULL) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end else if (Key_Value <= 4'd12) begin
        buf_nxt_s = '0;
        cnt_nxt_s = '0;
        op_nxt_s  = 2'(Key_Value - 4'd9);
      end else if (Key_Value == 4'd13) begin
        buf_nxt_s = '0;
        cnt_nxt_s = '0;
        op_nxt_s  = 2'd0;
      end else begin
        buf_nxt_s = buf_r;
        cnt_nxt_s = cnt_r;
        op_nxt_s  = op_r;
      end
    end else begin
      buf_nxt_s = buf_r;
      cnt_nxt_s = cnt_r;
      op_nxt_s  = op_r;
    end
  end

  // Entry state registers; buf_full tracks the count it is registered with.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      flag_d_r <= 1'b0;
      buf_r    <= '0;
      cnt_r    <= '0;
      op_r     <= 2'd0;
      full_r   <= 1'b0;
    end else begin
      flag_d_r <= Key_Flag;
      buf_r    <= buf_nxt_s;
      cnt_r    <= cnt_nxt_s;
      op_r     <= op_nxt_s;
      full_r   <= (cnt_nxt_s == CNT_FULL);
    end
  end

  // Free-running scan slot timer and digit index.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= '0;
      idx_r      <= (idx_r == IDX_LAST) ? IDX_W'(0) : idx_r + IDX_W'(1);
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      idx_r      <= idx_r;
    end
  end

  // Digit select and segment pattern for the digit under the scan index.
  always_comb begin
    sel_nxt_s = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
    seg_nxt_s = 8'hFF;
    if ((idx_r != IDX_W'(0)) && (CNT_W'(idx_r) >= cnt_r)) begin
      seg_nxt_s = 8'hFF;
    end else begin
      seg_nxt_s = seg_decode(buf_r[idx_r]);
    end
    // Decimal point on the rightmost digit flags a pending separator.
    if ((idx_r == IDX_W'(0)) && (op_r != 2'd0)) begin
      seg_nxt_s[7] = 1'b0;
    end else begin
      seg_nxt_s[7] = seg_nxt_s[7];
    end
  end

  // Display output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sel_r <= '1;
      seg_r <= 8'hFF;
    end else begin
      sel_r <= sel_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  // Pace counter advance; held at zero while pacing is disabled.
  always_comb begin
    pace_nxt_s = '0;
    if (!pace_en) begin
      pace_nxt_s = '0;
    end else if (pace_cnt_r == PACE_LAST) begin
      pace_nxt_s = '0;
    end else begin
      pace_nxt_s = pace_cnt_r + PACE_W'(1);
    end
  end

  // dly_done is high exactly while the counter sits at its last value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pace_cnt_r <= '0;
      dly_done_r <= 1'b0;
    end else begin
      pace_cnt_r <= pace_nxt_s;
      dly_done_r <= pace_en & (pace_nxt_s == PACE_LAST);
    end
  end

  assign dly_done = dly_done_r;
  assign sel      = sel_r;
  assign seg      = seg_r;
  assign buf_full = full_r;
  assign op_code  = op_r;

endmodule

// File: tb/tb_key_seg_display.sv
// Self-checking bench for key_seg_display: table of key events scored through a queue,
// plus idle scan, pacing and mid-event reset sequences.
module tb_key_seg_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int PACE_DIV = 10;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              Key_Flag;
  logic [3:0]        Key_Value;
  logic              pace_en;
  logic              dly_done;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;
  logic              buf_full;
  logic [1:0]        op_code;

  key_seg_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .PACE_DIV(PACE_DIV)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Key_Flag(Key_Flag), .Key_Value(Key_Value),
    .pace_en(pace_en), .dly_done(dly_done), .sel(sel), .seg(seg),
    .buf_full(buf_full), .op_code(op_code)
  );

  always #5 Clk = ~Clk;

  // segs holds the expected pattern per digit as {d3,d2,d1,d0}
  typedef struct packed {
    logic [3:0]  val;
    logic [3:0]  hold;
    logic [3:0]  cnt;
    logic        full;
    logic [1:0]  op;
    logic [31:0] segs;
  } vec_t;

  vec_t vecs [14];
  vec_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sel_digit(input logic [3:0] s);
    case (s)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  task automatic capture(output logic [31:0] segs, output logic [3:0] seen);
    int d;
    segs = '1;
    seen = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      d = sel_digit(sel);
      if (d >= 0) begin
        seen[d] = 1'b1;
        segs[d*8 +: 8] = seg;
      end
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge Clk);
    Key_Value = v.val;
    Key_Flag  = 1'b1;
    sb.push_back(v);
    repeat (v.hold) @(negedge Clk);
    Key_Flag  = 1'b0;
    Key_Value = 4'd0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic score(input string tag);
    vec_t        e;
    logic [31:0] segs;
    logic [3:0]  seen;
    if (sb.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_count"}, 32'(dut.cnt_r), 32'(e.cnt));
      check({tag, "_full"}, 32'(buf_full), 32'(e.full));
      check({tag, "_op"}, 32'(op_code), 32'(e.op));
      capture(segs, seen);
      check({tag, "_seen"}, 32'(seen), 32'hF);
      check({tag, "_segs"}, segs, e.segs);
    end
  endtask

  initial begin
    int pulses;
    int last;
    int first;
    int exp_d;
    vec_t rv;

    vecs[0]  = '{4'd7,  4'd5, 4'd1, 1'b0, 2'd0, 32'hFFFF_FFF8};
    vecs[1]  = '{4'd1,  4'd1, 4'd2, 1'b0, 2'd0, 32'hFFFF_F8F9};
    vecs[2]  = '{4'd2,  4'd1, 4'd3, 1'b0, 2'd0, 32'hFFF8_F9A4};
    vecs[3]  = '{4'd3,  4'd2, 4'd4, 1'b1, 2'd0, 32'hF8F9_A4B0};
    vecs[4]  = '{4'd4,  4'd1, 4'd4, 1'b1, 2'd0, 32'hF9A4_B099};
    vecs[5]  = '{4'd5,  4'd1, 4'd4, 1'b1, 2'd0, 32'hA4B0_9992};
    vecs[6]  = '{4'd14, 4'd1, 4'd4, 1'b1, 2'd0, 32'hA4B0_9992};
    vecs[7]  = '{4'd11, 4'd1, 4'd0, 1'b0, 2'd2, 32'hFFFF_FF40};
    vecs[8]  = '{4'd9,  4'd1, 4'd1, 1'b0, 2'd2, 32'hFFFF_FF10};
    vecs[9]  = '{4'd13, 4'd1, 4'd0, 1'b0, 2'd0, 32'hFFFF_FFC0};
    vecs[10] = '{4'd12, 4'd1, 4'd0, 1'b0, 2'd3, 32'hFFFF_FF40};
    vecs[11] = '{4'd10, 4'd1, 4'd0, 1'b0, 2'd1, 32'hFFFF_FF40};
    vecs[12] = '{4'd8,  4'd3, 4'd1, 1'b0, 2'd1, 32'hFFFF_FF00};
    vecs[13] = '{4'd15, 4'd1, 4'd1, 1'b0, 2'd1, 32'hFFFF_FF00};

    Rst_n     = 1'b0;
    Key_Flag  = 1'b0;
    Key_Value = 4'd0;
    pace_en   = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_full", 32'(buf_full), 32'd0);
    check("rst_op", 32'(op_code), 32'd0);
    check("rst_dly", 32'(dly_done), 32'd0);
    Rst_n = 1'b1;

    // idle scan: sel steps E,D,B,7 holding each for SCAN_DIV clocks
    for (int n = 1; n <= 32; n++) begin
      @(negedge Clk);
      exp_d = ((n - 1) / SCAN_DIV) % DIGITS;
      check("idle_sel", 32'(sel), 32'(~(4'b0001 << exp_d) & 4'hF));
      check("idle_seg", 32'(seg), (exp_d == 0) ? 32'hC0 : 32'hFF);
      check("idle_dly", 32'(dly_done), 32'd0);
    end

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      score($sformatf("vec%0d", i));
    end

    // pacing: one-cycle pulses every PACE_DIV clocks
    @(negedge Clk);
    pace_en = 1'b1;
    pulses = 0;
    last = -100;
    for (int i = 1; i <= 35; i++) begin
      @(negedge Clk);
      if (dly_done) begin
        if (pulses > 0) check("pace_spacing", 32'(i - last), 32'(PACE_DIV));
        last = i;
        pulses++;
      end
    end
    check("pace_pulses", 32'(pulses), 32'd3);
    pace_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (dly_done) pulses++;
    end
    check("pace_off_pulses", 32'(pulses), 32'd0);
    check("pace_off_cnt", 32'(dut.pace_cnt_r), 32'd0);
    pace_en = 1'b1;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      if (dly_done && first < 0) first = i;
    end
    check("pace_reenable", 32'((first == PACE_DIV - 1) || (first == PACE_DIV)), 32'd1);

    // reset lands while a key event is being presented
    @(negedge Clk);
    Key_Value = 4'd6;
    Key_Flag  = 1'b1;
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 32'hF);
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_full", 32'(buf_full), 32'd0);
    check("arst_op", 32'(op_code), 32'd0);
    check("arst_dly", 32'(dly_done), 32'd0);
    check("arst_count", 32'(dut.cnt_r), 32'd0);
    @(negedge Clk);
    Key_Flag = 1'b0;
    pace_en  = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    rv = '{4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 32'hFFFF_FFC0};
    sb.push_back(rv);
    score("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
